moving_average_var: RTL and testbench
=====================================

MOVING_AVERAGE_VAR -- requirements
Module: moving_average_var

Interface
REQ-001 SHALL have parameter MAX_POW, default 4; log2 of the largest supported window (window depth 2^MAX_POW).
REQ-002 SHALL take sample width word_width from opo_package; no local width parameter.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  1 = average; 0 = bypass.
REQ-006 SHALL have port avg_pow  input  $clog2(MAX_POW+1)  log2 of the active window N; values above MAX_POW are treated as MAX_POW.
REQ-007 SHALL have port clear  input  1  one-cycle request to flush history.
REQ-008 SHALL have port sample_in  input  word_width  signed two's-complement sample.
REQ-009 SHALL have port sample_in_valid  input  1  qualifies sample_in.
REQ-010 SHALL have port sample_out  output  word_width  signed average or bypassed sample (registered).
REQ-011 SHALL have port sample_out_valid  output  1  one-cycle strobe qualifying sample_out.
REQ-012 SHALL have port filled  output  1  high when the window holds N valid samples.

Function
REQ-013 SHALL keep a history of 2^MAX_POW samples (newest first) and a signed sum of word_width+MAX_POW bits.
REQ-014 SHALL, on each valid sample in averaging mode, update sum <= sum + sample_in - tap[N-1], where tap[N-1] is the sample that entered N valid samples earlier; slots not yet written read as 0.
REQ-015 SHALL compute sample_out = (sum + 2^(P-1)) >>> P (arithmetic shift, round half up) for P = active avg_pow >= 1; P = 0 passes the sum unchanged.
REQ-016 SHALL clamp the rounded result to the word_width signed range; no wrap-around.
REQ-017 SHALL register sample_out and sample_out_valid one cycle after the valid input; latency 1 cycle in both modes.
REQ-018 SHALL implement two states: FILL (fewer than N samples since flush) and RUN.
REQ-019 SHALL count valid samples in FILL; on the Nth, go to RUN and assert filled on the same cycle as that sample's output.
REQ-020 SHALL hold sample_out_valid low in FILL while averaging; outputs start with the first complete window.
REQ-021 SHALL register avg_pow on every valid sample; if it differs from the active value, flush (zero the sum, history and fill count), then go to FILL with the new value, counting the current sample as the first.
REQ-022 SHALL treat clear as a flush without processing a sample; when clear and sample_in_valid are high together, the sample is the first of the new window.
REQ-023 SHALL, with enable = 0, output sample_in with sample_out_valid = sample_in_valid, still update the history and sum, and leave FILL/RUN unaffected.
REQ-024 SHALL output sample_out_valid = 0 on cycles where sample_in_valid = 0; sample_out holds its last value.
REQ-025 SHALL accept back-to-back valid samples every cycle with no stall.

Reset
REQ-026 SHALL, on rst high at a clock edge, set sample_out = 0, sample_out_valid = 0, filled = 0, sum = 0, history = 0, fill count = 0, state = FILL, active avg_pow = 0.
REQ-027 SHALL let rst override clear, enable and sample_in_valid on the same cycle; a reset mid-fill discards the partial window.

Structure
REQ-028 SHALL take word_width and an enum type for the FILL/RUN state from opo_package.
REQ-029 SHALL place the history in one sub-module, tap_delay_line (depth 2^MAX_POW, write-enable, synchronous clear, variable read tap).

Verification (word_width = 16, MAX_POW = 4)
REQ-030 Scenario 1: avg_pow = 2, inputs 4,8,12,16,20 -> no valid output for the first three; then outputs 10, 14; filled rises with the 4th.
REQ-031 Scenario 2: avg_pow = 1, inputs -3,-2 -> output -2 (-5 + 1 = -4, shifted right 1).
REQ-032 Scenario 3: avg_pow = 2, four samples of 32767 -> output 32767, no wrap; then four of -32768 -> -32768.
REQ-033 Scenario 4: in RUN at avg_pow = 2, switch to 3 with the next sample -> filled drops, no valid output until 8 samples; then the mean of those 8.
REQ-034 Scenario 5: enable = 0, input 1234 valid -> output 1234 one cycle later; clear together with valid 100 at avg_pow = 0 -> output 100.
REQ-035 Scenario 6: rst pulsed after 2 of 4 fill samples -> all outputs 0; the next 4 samples 1,1,1,1 -> output 1.

Source files
------------

// File: rtl/opo_package.sv
// opo_package
// Shared definitions for the averaging datapath.
//   word_width   : width of every signed sample travelling through the filter
//   fill_state_e : FILL while the window is still being populated after a flush,
//                  RUN once it holds a complete set of samples
package opo_package;

    localparam int word_width = 16;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fill_state_e;

endpackage

// File: rtl/tap_delay_line.sv
// tap_delay_line
// Shift-register history of the most recent samples, newest in slot 0.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, zeroes every slot
//   clear   : synchronous flush; zeroes every slot (a simultaneous write lands in slot 0)
//   wr_en   : shift the history by one and insert wr_data at slot 0
//   wr_data : sample to insert
//   rd_sel  : slot index to read (0 = newest stored sample)
//   rd_data : combinational read of the selected slot
module tap_delay_line
    import opo_package::*;
#(
    parameter int DEPTH_POW = 4,
    parameter int WIDTH     = word_width
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic [DEPTH_POW-1:0]    rd_sel,
    output logic signed [WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << DEPTH_POW;

    logic signed [WIDTH-1:0] taps [DEPTH];

    // A flush that coincides with a write keeps only the incoming sample, so the
    // new window starts with it and everything older reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else if (clear) begin
            for (int i = 1; i < DEPTH; i++) taps[i] <= '0;
            taps[0] <= wr_en ? wr_data : '0;
        end else if (wr_en) begin
            taps[0] <= wr_data;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign rd_data = taps[rd_sel];

endmodule

// File: rtl/moving_average_var.sv
// moving_average_var
// Running mean over the last 2^P samples, with P selectable at run time.
//   clk              : rising-edge clock
//   rst              : synchronous active-high reset
//   enable           : 1 = output the average, 0 = pass samples straight through
//   avg_pow          : log2 of the window length, saturated at MAX_POW
//   clear            : flush the history (the coincident sample, if any, starts the new window)
//   sample_in        : signed input sample, qualified by sample_in_valid
//   sample_out       : registered signed average or bypassed sample
//   sample_out_valid : one-cycle strobe qualifying sample_out
//   filled           : window currently holds a complete set of samples
module moving_average_var
    import opo_package::*;
#(
    parameter int MAX_POW = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [$clog2(MAX_POW+1)-1:0]   avg_pow,
    input  logic                           clear,
    input  logic signed [word_width-1:0]   sample_in,
    input  logic                           sample_in_valid,
    output logic signed [word_width-1:0]   sample_out,
    output logic                           sample_out_valid,
    output logic                           filled
);

    localparam int PW = $clog2(MAX_POW+1);
    localparam int SW = word_width + MAX_POW;
    localparam logic [PW-1:0]        MAX_POW_P = PW'(MAX_POW);
    localparam logic signed [SW:0]   OUT_MAX   = (SW+1)'((2**(word_width-1)) - 1);
    localparam logic signed [SW:0]   OUT_MIN   = (SW+1)'(-(2**(word_width-1)));

    logic [PW-1:0]                 eff_pow;
    logic [PW-1:0]                 active_pow;
    logic [MAX_POW:0]              win_len;
    logic [MAX_POW-1:0]            tap_sel;
    logic signed [word_width-1:0]  tap_data;
    logic                          flush;

    logic signed [SW-1:0]          sum;
    logic signed [SW-1:0]          sum_next;
    logic signed [SW:0]            round_bias;
    logic signed [SW:0]            rounded;
    logic signed [word_width-1:0]  avg_clamped;

    fill_state_e                   state;
    fill_state_e                   state_next;
    logic [MAX_POW:0]              fill_cnt;
    logic [MAX_POW:0]              fill_cnt_next;
    logic signed [word_width-1:0]  out_next;
    logic                          out_valid_next;

    tap_delay_line #(
        .DEPTH_POW (MAX_POW),
        .WIDTH     (word_width)
    ) u_history (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .wr_en   (sample_in_valid),
        .wr_data (sample_in),
        .rd_sel  (tap_sel),
        .rd_data (tap_data)
    );

    // Window geometry from the requested power; the sample leaving the window is
    // the one stored N-1 slots behind the newest stored sample.
    always_comb begin
        eff_pow = (avg_pow > MAX_POW_P) ? MAX_POW_P : avg_pow;
        win_len = (MAX_POW+1)'(1) << eff_pow;
        tap_sel = win_len[MAX_POW-1:0] - MAX_POW'(1);
    end

    // A new window length only takes effect with a sample, so the comparison
    // against the active length is qualified by sample_in_valid.
    assign flush = clear | (sample_in_valid & (eff_pow != active_pow));

    // Running sum plus round-half-up division by 2^P; a flush restarts the sum
    // from the current sample alone.
    always_comb begin
        sum_next = flush ? '0 : sum;
        if (sample_in_valid) begin
            if (flush) begin
                sum_next = SW'(sample_in);
            end else begin
                sum_next = sum + SW'(sample_in) - SW'(tap_data);
            end
        end
        round_bias = ((SW+1)'(1) << eff_pow) >> 1;
        rounded    = ((SW+1)'(sum_next) + round_bias) >>> eff_pow;
        if (rounded > OUT_MAX) begin
            avg_clamped = OUT_MAX[word_width-1:0];
        end else if (rounded < OUT_MIN) begin
            avg_clamped = OUT_MIN[word_width-1:0];
        end else begin
            avg_clamped = rounded[word_width-1:0];
        end
    end

    // Fill tracking and output selection. Bypass still honours a flush but does
    // not advance the fill count, so FILL/RUN only reflects averaged samples.
    always_comb begin
        state_next     = state;
        fill_cnt_next  = fill_cnt;
        out_next       = sample_out;
        out_valid_next = 1'b0;
        if (flush) begin
            state_next    = FILL;
            fill_cnt_next = '0;
        end
        if (sample_in_valid) begin
            if (enable) begin
                if (state_next == FILL) begin
                    fill_cnt_next = fill_cnt_next + (MAX_POW+1)'(1);
                    if (fill_cnt_next == win_len) state_next = RUN;
                end
                if (state_next == RUN) begin
                    out_next       = avg_clamped;
                    out_valid_next = 1'b1;
                end
            end else begin
                out_next       = sample_in;
                out_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum              <= '0;
            state            <= FILL;
            fill_cnt         <= '0;
            active_pow       <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
        end else begin
            sum              <= sum_next;
            state            <= state_next;
            fill_cnt         <= fill_cnt_next;
            sample_out       <= out_next;
            sample_out_valid <= out_valid_next;
            if (sample_in_valid) active_pow <= eff_pow;
        end
    end

    assign filled = (state == RUN);

endmodule

// File: tb/tb_moving_average_var.sv
// tb_moving_average_var
// Drives moving_average_var (word_width 16, MAX_POW 4) from a vector table and
// a few hand-written sequences; each driven cycle pushes its expected outputs to
// a queue that a monitor pops one cycle later.
module tb_moving_average_var;
    import opo_package::*;

    localparam int NC = -99999;   // "don't check" marker for expected values

    typedef struct {
        int rst;
        int en;
        int pow;
        int clr;
        int vld;
        int x;
        int exp_vld;
        int exp_out;
        int exp_fil;
    } vec_t;

    typedef struct {
        int id;
        int exp_vld;
        int exp_out;
        int exp_fil;
    } exp_t;

    logic                          clk;
    logic                          rst;
    logic                          enable;
    logic [2:0]                    avg_pow;
    logic                          clear;
    logic signed [word_width-1:0]  sample_in;
    logic                          sample_in_valid;
    logic signed [word_width-1:0]  sample_out;
    logic                          sample_out_valid;
    logic                          filled;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   vec_id = 0;

    moving_average_var #(.MAX_POW(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .avg_pow          (avg_pow),
        .clear            (clear),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .filled           (filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int r, int e, int p, int c, int v, int x,
                                int ev, int eo, int ef);
        vec_t t;
        t.rst = r; t.en = e; t.pow = p; t.clr = c; t.vld = v; t.x = x;
        t.exp_vld = ev; t.exp_out = eo; t.exp_fil = ef;
        return t;
    endfunction

    // Drive one cycle of inputs at the falling edge and record what should come out.
    task automatic apply_stimulus(input vec_t t);
        exp_t e;
        @(negedge clk);
        rst             = t.rst[0];
        enable          = t.en[0];
        avg_pow         = 3'(t.pow);
        clear           = t.clr[0];
        sample_in_valid = t.vld[0];
        sample_in       = word_width'(t.x);
        e.id      = vec_id;
        e.exp_vld = t.exp_vld;
        e.exp_out = t.exp_out;
        e.exp_fil = t.exp_fil;
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic check_output(input exp_t e);
        total++;
        if (int'(sample_out_valid) != e.exp_vld) begin
            bad++;
            $display("[TB] FAIL vec%0d valid: got %0d want %0d", e.id, sample_out_valid, e.exp_vld);
        end
        if (e.exp_out != NC) begin
            total++;
            if (int'(sample_out) != e.exp_out) begin
                bad++;
                $display("[TB] FAIL vec%0d sample_out: got %0d want %0d", e.id, sample_out, e.exp_out);
            end
        end
        if (e.exp_fil >= 0) begin
            total++;
            if (int'(filled) != e.exp_fil) begin
                bad++;
                $display("[TB] FAIL vec%0d filled: got %0d want %0d", e.id, filled, e.exp_fil);
            end
        end
    endtask

    // Monitor: one expected record per driven cycle, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; avg_pow = '0; clear = 1'b0;
        sample_in = '0; sample_in_valid = 1'b0;

        // Reset state
        vecs.push_back(mk(1,1,0,0,0,0,     0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,     0,0,0));
        // Window of 4: 4,8,12,16,20 -> 10, 14
        vecs.push_back(mk(0,1,2,0,1,4,     0,NC,0));
        vecs.push_back(mk(0,1,2,0,1,8,     0,NC,0));
        vecs.push_back(mk(0,1,2,0,1,12,    0,NC,0));
        vecs.push_back(mk(0,1,2,0,1,16,    1,10,1));
        vecs.push_back(mk(0,1,2,0,1,20,    1,14,1));
        // Idle cycle holds the output; clear alone empties the window
        vecs.push_back(mk(0,1,2,0,0,0,     0,14,1));
        vecs.push_back(mk(0,1,2,1,0,0,     0,14,0));
        // Window of 2 with negative rounding: -3,-2 -> -2
        vecs.push_back(mk(0,1,1,0,1,-3,    0,NC,0));
        vecs.push_back(mk(0,1,1,0,1,-2,    1,-2,1));
        // Full-scale samples, no wrap-around
        vecs.push_back(mk(0,1,2,0,1,32767, 0,NC,0));
        vecs.push_back(mk(0,1,2,0,1,32767, 0,NC,0));
        vecs.push_back(mk(0,1,2,0,1,32767, 0,NC,0));
        vecs.push_back(mk(0,1,2,0,1,32767, 1,32767,1));
        vecs.push_back(mk(0,1,2,0,1,-32768,1,16383,1));
        vecs.push_back(mk(0,1,2,0,1,-32768,1,0,1));
        vecs.push_back(mk(0,1,2,0,1,-32768,1,-16384,1));
        vecs.push_back(mk(0,1,2,0,1,-32768,1,-32768,1));
        // Bypass, then clear with a sample at window 1, then average of one sample
        vecs.push_back(mk(0,0,2,0,1,1234,  1,1234,1));
        vecs.push_back(mk(0,0,0,1,1,100,   1,100,-1));
        vecs.push_back(mk(0,1,0,0,1,7,     1,7,1));
        // Out-of-range power saturates to 16: behaves like avg_pow = 4
        vecs.push_back(mk(0,1,7,0,1,16,    0,NC,0));

        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);

        // Remaining 15 samples of the saturated window of 16: mean of sixteen 16s
        for (int i = 0; i < 15; i++) begin
            if (i == 14) apply_stimulus(mk(0,1,7,0,1,16, 1,16,1));
            else         apply_stimulus(mk(0,1,7,0,1,16, 0,NC,0));
        end

        // Window change in RUN: 1..5 at window 4, then 10..80 at window 8
        for (int k = 1; k <= 5; k++) begin
            if (k < 4)       apply_stimulus(mk(0,1,2,0,1,k, 0,NC,0));
            else if (k == 4) apply_stimulus(mk(0,1,2,0,1,k, 1,3,1));
            else             apply_stimulus(mk(0,1,2,0,1,k, 1,4,1));
        end
        for (int k = 1; k <= 8; k++) begin
            if (k < 8) apply_stimulus(mk(0,1,3,0,1,10*k, 0,NC,0));
            else       apply_stimulus(mk(0,1,3,0,1,10*k, 1,45,1));
        end

        // Reset partway through a fill, with a valid sample that must be ignored
        apply_stimulus(mk(0,1,2,0,1,9,  0,NC,0));
        apply_stimulus(mk(0,1,2,0,1,9,  0,NC,0));
        apply_stimulus(mk(1,1,2,1,1,55, 0,0,0));
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) apply_stimulus(mk(0,1,2,0,1,1, 0,NC,0));
            else       apply_stimulus(mk(0,1,2,0,1,1, 1,1,1));
        end

        @(negedge clk);
        sample_in_valid = 1'b0;
        clear           = 1'b0;
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
